// File: rtl/capture_stop_pkg.sv
// capture_stop_pkg
//   Shared types and constants for the multi-channel capture stop gate.
//   state_t : per-channel FSM state (RUN, STOP, LOCK)
//   cause_t : reported stop cause, encoded exactly as it appears on oCause
//   DEFAULT_UNLOCK_KEY : default value of the unlock key parameter
package capture_stop_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STOP = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_CMD   = 2'd1,
        CAUSE_BURST = 2'd2,
        CAUSE_INT   = 2'd3
    } cause_t;

    localparam logic [15:0] DEFAULT_UNLOCK_KEY = 16'hA5C3;

endpackage

// File: rtl/stop_channel.sv
// stop_channel
//   One capture channel: RUN/STOP/LOCK state machine, burst frame counter
//   and stop-cause register. All outputs are registered.
//   The FSM state is fully observable on the outputs:
//   RUN = {locked,stop} 2'b00, STOP = 2'b01, LOCK = 2'b11.
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   stop_req     : stop request (level or pulse)
//   go_req       : go request
//   lock_evt     : channel interrupt OR global interrupt
//   key_ok       : unlock strobe with a matching key
//   frame_done   : 1-cycle end-of-frame pulse
//   burst_mode   : stop after burst_len frames (sampled on go)
//   burst_len    : burst length, 0 = unlimited (sampled on go)
//   stop         : channel must not start new frames
//   locked       : channel is in LOCK
//   cause        : reason for the last stop
//   frame_cnt    : frames remaining in the burst; 0 when unlimited or not running
module stop_channel
    import capture_stop_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_req,
    input  logic             go_req,
    input  logic             lock_evt,
    input  logic             key_ok,
    input  logic             frame_done,
    input  logic             burst_mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             stop,
    output logic             locked,
    output cause_t           cause,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;

        if (lock_evt) begin
            // A lock event wins over everything, from any state.
            state_d = LOCK;
            cause_d = CAUSE_INT;
        end else begin
            unique case (state_q)
                LOCK: begin
                    // Unlocking lands in STOP so the channel needs an explicit go.
                    if (key_ok) begin
                        state_d = STOP;
                    end
                end
                RUN: begin
                    if (stop_req) begin
                        // Stop wins over a coincident frame_done; counter held.
                        state_d = STOP;
                        cause_d = CAUSE_CMD;
                    end else if (frame_done && (cnt_q != '0)) begin
                        // Zero means unlimited, so the counter never wraps.
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = STOP;
                            cause_d = CAUSE_BURST;
                        end
                    end
                end
                STOP: begin
                    if (go_req && !stop_req) begin
                        state_d = RUN;
                        cause_d = CAUSE_NONE;
                        cnt_d   = (burst_mode && (burst_len != '0)) ? burst_len : '0;
                    end
                end
                default: begin
                    state_d = STOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= '0;
            stop      <= 1'b0;
            locked    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            stop      <= (state_d != RUN);
            locked    <= (state_d == LOCK);
            // A held counter is hidden while the channel is not running.
            frame_cnt <= (state_d == RUN) ? cnt_d : '0;
        end
    end

    assign cause = cause_q;

endmodule

// File: rtl/capture_stop_ctrl.sv
// capture_stop_ctrl
//   Multi-channel run/stop gate between command logic and the per-channel
//   capture enables. Each channel is an independent stop_channel; only the
//   global interrupt and the unlock strobe are shared.
// Ports
//   iCLK, iRST  : clock, synchronous active-high reset
//   iStop       : per-channel stop request
//   iGo         : per-channel go request
//   iInterrupt  : per-channel fault, locks that channel
//   iGlobalInt  : locks every channel
//   iFrameDone  : per-channel end-of-frame pulse
//   iBurstMode  : per-channel burst enable (sampled on go)
//   iBurstLen   : burst length shared by all channels (sampled on go), 0 = unlimited
//   iUnlock     : unlock strobe for all locked channels
//   iUnlockKey  : must equal UNLOCK_KEY for iUnlock to take effect
//   oStop       : channel stopped or locked
//   oLocked     : channel in LOCK
//   oCause      : 2 bits per channel: 0 NONE, 1 CMD, 2 BURST, 3 INT
//   oFrameCnt   : CNT_W bits per channel: frames left in the current burst
module capture_stop_ctrl
    import capture_stop_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 8,
    parameter logic [15:0] UNLOCK_KEY = DEFAULT_UNLOCK_KEY
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [NUM_CH-1:0]       iStop,
    input  logic [NUM_CH-1:0]       iGo,
    input  logic [NUM_CH-1:0]       iInterrupt,
    input  logic                    iGlobalInt,
    input  logic [NUM_CH-1:0]       iFrameDone,
    input  logic [NUM_CH-1:0]       iBurstMode,
    input  logic [CNT_W-1:0]        iBurstLen,
    input  logic                    iUnlock,
    input  logic [15:0]             iUnlockKey,
    output logic [NUM_CH-1:0]       oStop,
    output logic [NUM_CH-1:0]       oLocked,
    output logic [2*NUM_CH-1:0]     oCause,
    output logic [CNT_W*NUM_CH-1:0] oFrameCnt
);

    logic key_ok;

    assign key_ok = iUnlock && (iUnlockKey == UNLOCK_KEY);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cause_t ch_cause;

        stop_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk       (iCLK),
            .rst       (iRST),
            .stop_req  (iStop[g]),
            .go_req    (iGo[g]),
            .lock_evt  (iInterrupt[g] | iGlobalInt),
            .key_ok    (key_ok),
            .frame_done(iFrameDone[g]),
            .burst_mode(iBurstMode[g]),
            .burst_len (iBurstLen),
            .stop      (oStop[g]),
            .locked    (oLocked[g]),
            .cause     (ch_cause),
            .frame_cnt (oFrameCnt[CNT_W*g +: CNT_W])
        );

        assign oCause[2*g +: 2] = ch_cause;
    end

endmodule

// File: tb/tb_capture_stop_ctrl.sv
module tb_capture_stop_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int W      = NUM_CH + NUM_CH + 2*NUM_CH + CNT_W*NUM_CH;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       stop_in, go_in, intr_in, fd_in, bm_in;
  logic                    gint_in;
  logic [CNT_W-1:0]        blen_in;
  logic                    unl_in;
  logic [15:0]             key_in;
  logic [NUM_CH-1:0]       stop_out, locked_out;
  logic [2*NUM_CH-1:0]     cause_out;
  logic [CNT_W*NUM_CH-1:0] cnt_out;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  stop, go, intr;
    logic        gint;
    logic [3:0]  fd, bm;
    logic [7:0]  blen;
    logic        unl;
    logic [15:0] key;
    logic [3:0]  e_stop, e_lock;
    logic [7:0]  e_cause;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  capture_stop_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .UNLOCK_KEY(16'hA5C3)) dut (
    .iCLK(clk), .iRST(rst), .iStop(stop_in), .iGo(go_in), .iInterrupt(intr_in),
    .iGlobalInt(gint_in), .iFrameDone(fd_in), .iBurstMode(bm_in), .iBurstLen(blen_in),
    .iUnlock(unl_in), .iUnlockKey(key_in), .oStop(stop_out), .oLocked(locked_out),
    .oCause(cause_out), .oFrameCnt(cnt_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic [3:0] s, g, i,
                              input logic gi, input logic [3:0] f, b, input logic [7:0] bl,
                              input logic u, input logic [15:0] k,
                              input logic [3:0] es, el, input logic [7:0] ec,
                              input logic [31:0] en);
    vec_t v;
    v.name = name; v.rst = r; v.stop = s; v.go = g; v.intr = i; v.gint = gi;
    v.fd = f; v.bm = b; v.blen = bl; v.unl = u; v.key = k;
    v.e_stop = es; v.e_lock = el; v.e_cause = ec; v.e_cnt = en;
    return v;
  endfunction

  task automatic clear_inputs();
    stop_in = '0; go_in = '0; intr_in = '0; gint_in = 1'b0; fd_in = '0;
    bm_in = '0; blen_in = '0; unl_in = 1'b0; key_in = '0;
  endtask

  // scoreboard compare: pop the oldest expectation against the current outputs
  task automatic check(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    act_v = {stop_out, locked_out, cause_out, cnt_out};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued, got %h", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got stop=%b lock=%b cause=%h cnt=%h, expected stop=%b lock=%b cause=%h cnt=%h",
                 name, act_v[47:44], act_v[43:40], act_v[39:32], act_v[31:0],
                 exp_v[47:44], exp_v[43:40], exp_v[39:32], exp_v[31:0]);
      end
    end
  endtask

  // driver: apply one vector for one clock edge, queue its expected result
  task automatic drive(input vec_t v);
    rst = v.rst; stop_in = v.stop; go_in = v.go; intr_in = v.intr; gint_in = v.gint;
    fd_in = v.fd; bm_in = v.bm; blen_in = v.blen; unl_in = v.unl; key_in = v.key;
    exp_q.push_back({v.e_stop, v.e_lock, v.e_cause, v.e_cnt});
    @(posedge clk);
    #1;
    check(v.name);
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    //          name            rst stop     go       intr     gi  fd       bm       blen   unl key       estop    elock    ecause eCnt
    vecs.push_back(mk("reset_hold",  1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("idle_after",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("stop_ch1",    0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0010, 4'b0000, 8'h04, 32'h0));
    vecs.push_back(mk("go_ch1",      0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("stop_ch0",    0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0001, 4'b0000, 8'h01, 32'h0));
    vecs.push_back(mk("burst_go3",   0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd3,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h3));
    vecs.push_back(mk("burst_fd1",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd9,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h2));
    vecs.push_back(mk("burst_hold",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h2));
    vecs.push_back(mk("burst_fd2",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h1));
    vecs.push_back(mk("burst_end",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0001, 4'b0000, 8'h02, 32'h0));
    vecs.push_back(mk("burst_fd4",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0001, 4'b0000, 8'h02, 32'h0));
    vecs.push_back(mk("burst_go2",   0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd2,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h2));
    vecs.push_back(mk("stop_fd",     0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0001, 4'b0000, 8'h01, 32'h0));
    vecs.push_back(mk("go_unlim",    0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 8'd5,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("stop_go_ch3", 0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b1000, 4'b0000, 8'h40, 32'h0));
    vecs.push_back(mk("go_ch3",      0, 4'b0000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("go_in_run",   0, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0100, 8'd5,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("int_ch2",     0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0100, 4'b0100, 8'h30, 32'h0));
    vecs.push_back(mk("lock_go",     0, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0100, 4'b0100, 8'h30, 32'h0));
    vecs.push_back(mk("lock_stop",   0, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0100, 4'b0100, 8'h30, 32'h0));
    vecs.push_back(mk("bad_key",     0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  1, 16'h0000, 4'b0100, 4'b0100, 8'h30, 32'h0));
    vecs.push_back(mk("good_key",    0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  1, 16'hA5C3, 4'b0100, 4'b0000, 8'h30, 32'h0));
    vecs.push_back(mk("go_unlocked", 0, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("gint_unlock", 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 8'd0,  1, 16'hA5C3, 4'b1111, 4'b1111, 8'hFF, 32'h0));
    vecs.push_back(mk("unlock_int1", 0, 4'b0000, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0000, 8'd0,  1, 16'hA5C3, 4'b1111, 4'b0010, 8'hFF, 32'h0));
    vecs.push_back(mk("go_after_ul", 0, 4'b0000, 4'b1101, 4'b0000, 0, 4'b1111, 4'b0000, 8'd0,  0, 16'h0000, 4'b0010, 4'b0010, 8'h0C, 32'h0));
    vecs.push_back(mk("stop_ch0_b",  0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0011, 4'b0010, 8'h0D, 32'h0));
    vecs.push_back(mk("burst_go4",   0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd4,  0, 16'h0000, 4'b0010, 4'b0010, 8'h0C, 32'h4));
    vecs.push_back(mk("burst4_fd",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0010, 4'b0010, 8'h0C, 32'h3));
    vecs.push_back(mk("rst_mid",     1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("fd_after_rst",0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b1111, 8'd7,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("fd_all",      0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h0));
    vecs.push_back(mk("stop_ch1_b",  0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0,  0, 16'h0000, 4'b0010, 4'b0000, 8'h04, 32'h0));
    vecs.push_back(mk("burst_go1",   0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 8'd1,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'h100));
    vecs.push_back(mk("burst1_end",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 8'd0,  0, 16'h0000, 4'b0010, 4'b0000, 8'h08, 32'h0));
    vecs.push_back(mk("burst_go255", 0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 8'd255,0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'hFF00));
    vecs.push_back(mk("burst255_fd", 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 8'd0,  0, 16'h0000, 4'b0000, 4'b0000, 8'h00, 32'hFE00));

    foreach (vecs[i]) drive(vecs[i]);

    // unlimited burst on ch0: 300 frames with random gaps, no stop, count stays 0
    drive(mk("unl_stop", 0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0, 0, 16'h0, 4'b0001, 4'b0000, 8'h01, 32'hFE00));
    drive(mk("unl_go",   0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd0, 0, 16'h0, 4'b0000, 4'b0000, 8'h00, 32'hFE00));
    for (int f = 0; f < 300; f++) begin
      drive(mk("unl_frame", 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 8'd0, 0, 16'h0, 4'b0000, 4'b0000, 8'h00, 32'hFE00));
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++)
        drive(mk("unl_gap", 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0, 0, 16'h0, 4'b0000, 4'b0000, 8'h00, 32'hFE00));
    end

    // lock mid-burst, unlock, reload; lock beats a coincident last frame
    drive(mk("lk_mid",     0, 4'b0000, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0000, 8'd0, 0, 16'h0,    4'b0010, 4'b0010, 8'h0C, 32'h0));
    drive(mk("lk_badkey",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0, 1, 16'hA5C2, 4'b0010, 4'b0010, 8'h0C, 32'h0));
    drive(mk("lk_unlock",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0, 1, 16'hA5C3, 4'b0010, 4'b0000, 8'h0C, 32'h0));
    drive(mk("lk_reload",  0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 8'd2, 0, 16'h0,    4'b0000, 4'b0000, 8'h00, 32'h200));
    drive(mk("lk_fd",      0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 8'd0, 0, 16'h0,    4'b0000, 4'b0000, 8'h00, 32'h100));
    drive(mk("lk_fd_int",  0, 4'b0000, 4'b0000, 4'b0010, 0, 4'b0010, 4'b0000, 8'd0, 0, 16'h0,    4'b0010, 4'b0010, 8'h0C, 32'h0));
    drive(mk("lk_ul_go",   0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 8'd3, 1, 16'hA5C3, 4'b0010, 4'b0000, 8'h0C, 32'h0));

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_stop_ctrl.md
Name: capture_stop_ctrl

Overview:
- Multi-channel run/stop gate for the capture pipeline. Generalises the single-channel stop latch to NUM_CH independent channels.
- Each channel adds:
  - a burst mode that auto-stops after a programmed number of frames;
  - per-channel and global interrupt lockout;
  - a keyed unlock path;
  - a reported stop cause.
- Sits between the control/command logic and the per-channel image capture enables. oStop[ch] high means channel ch must not start new frames.

Parameters:
NUM_CH, 4, number of independent capture channels (1..16)
CNT_W, 8, width of burst length and frame counter
UNLOCK_KEY, 16'hA5C3, 16-bit value iUnlockKey must equal to release a lock

Ports:
iCLK  input  1  single clock; all state changes on rising edge
iRST  input  1  reset, synchronous, active-high
iStop  input  NUM_CH  per-channel stop request, level or pulse
iGo  input  NUM_CH  per-channel go request
iInterrupt  input  NUM_CH  per-channel fault/interrupt; locks that channel
iGlobalInt  input  1  locks all channels
iFrameDone  input  NUM_CH  1-cycle pulse at end of each captured frame
iBurstMode  input  NUM_CH  1 = channel stops after iBurstLen frames
iBurstLen  input  CNT_W  burst length, sampled on go; 0 = unlimited
iUnlock  input  1  unlock strobe, applies to all locked channels
iUnlockKey  input  16  must equal UNLOCK_KEY when iUnlock is high
oStop  output  NUM_CH  1 = channel stopped or locked
oLocked  output  NUM_CH  1 = channel in LOCK state
oCause  output  2*NUM_CH  per channel, bits [2ch+1:2ch]: 0 NONE, 1 CMD, 2 BURST, 3 INT
oFrameCnt  output  CNT_W*NUM_CH  per channel: frames remaining in current burst; 0 when unlimited or stopped

Behaviour:
- Per-channel FSM states: RUN, STOP, LOCK. All outputs are registered.
- Reset (iRST high at an edge, at any time including mid-burst):
  - every channel goes to RUN; oStop=0, oLocked=0, oCause=NONE, oFrameCnt=0;
  - the frame counter is cleared.
- Priority within one cycle, highest first: lock event > unlock > iStop > burst expiry > iGo.
- Lock event = iInterrupt[ch] | iGlobalInt.
  - From any state, go to LOCK next edge with cause INT; oStop=1 and oLocked=1 one cycle after the event.
- LOCK:
  - iStop and iGo are ignored.
  - Exit only when iUnlock=1, iUnlockKey==UNLOCK_KEY and no lock event that cycle. The channel then goes to STOP, not RUN; cause stays INT.
  - A wrong key has no effect.
- RUN:
  - iStop → STOP, cause CMD.
  - In burst mode with a nonzero count, each iFrameDone decrements the counter.
  - When the counter is 1 and iFrameDone arrives, go to STOP with cause BURST; the counter reads 0.
  - iGo while in RUN is ignored; it does not reload the counter.
- STOP:
  - iGo (without iStop) → RUN, cause NONE.
  - If iBurstMode[ch]=1 and iBurstLen≠0, load the counter with iBurstLen on that edge; otherwise set the counter to 0, meaning unlimited.
- Simultaneous iStop and iGo: stop wins.
- iFrameDone on the same edge as iStop: stop wins, cause CMD, counter held.
- iFrameDone while in STOP or LOCK: ignored.
- Counter never wraps. Decrement happens only when the counter is nonzero.
- Changing iBurstMode or iBurstLen mid-burst has no effect until the next go.
- Latency from any input to output is 1 cycle. No combinational input-to-output paths.
- Channels are fully independent except for the shared iGlobalInt and iUnlock.

Decomposition:
- Package capture_stop_pkg holds:
  - state enum {RUN, STOP, LOCK};
  - cause enum {CAUSE_NONE=0, CAUSE_CMD=1, CAUSE_BURST=2, CAUSE_INT=3};
  - default UNLOCK_KEY constant.
- Sub-module stop_channel: one channel's FSM, counter and cause register, parametrised by CNT_W.
- Top level:
  - generate-loops NUM_CH instances;
  - computes key_ok = iUnlock & (iUnlockKey==UNLOCK_KEY) once and fans it out with iGlobalInt;
  - packs the per-channel outputs into oStop, oLocked, oCause and oFrameCnt.

Test Plan:
- Reset release with no other inputs → all oStop=0, oCause=0, oFrameCnt=0. iStop[1] pulse → oStop=4'b0010 next cycle, cause[1]=CMD; iGo[1] → oStop=0, cause NONE.
- Ch0 iBurstMode=1, iBurstLen=3, then stop and go → oFrameCnt[0]=3. After three iFrameDone[0] pulses: counts 2, 1, 0; oStop[0]=1 on the cycle after the third pulse, cause BURST. A fourth pulse changes nothing.
- iBurstLen=0 with burst mode → 300 frames with no stop (CNT_W=8), counter stays 0.
- iInterrupt[2] while running → oStop[2]=1 and oLocked[2]=1 next cycle, cause INT. iGo[2] is ignored. iUnlock with key 16'h0000 → still locked. iUnlock with 16'hA5C3 → STOP with oLocked=0; then iGo → RUN.
- iGlobalInt together with a valid iUnlock → all channels LOCK, since lock beats unlock. iStop and iGo together on ch3 → STOP.
- iRST asserted mid-burst with ch1 locked → next cycle all RUN, outputs zero; a subsequent iFrameDone is ignored because burst mode was not reloaded.
